// File: rtl/wb_stream_writer_ctrl_pkg.sv
// Shared constants for the stream writer: Wishbone CTI/BTE codes and sequencer states.
// Imported by the controller so bus encodings live in one place.
package wb_stream_writer_ctrl_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

endpackage

// File: rtl/wb_stream_writer_ctrl.sv
// Stream writer sequencer: reads buf_size words from start_adr as incrementing Wishbone
// bursts and forwards each acked word straight into the downstream FIFO.
module wb_stream_writer_ctrl
  import wb_stream_writer_ctrl_pkg::*;
#(
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int FIFO_AW = 5
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_n_i,
  input  logic                 enable,
  input  logic [WB_AW-1:0]     start_adr,
  input  logic [WB_AW-1:0]     buf_size,
  input  logic [WB_AW-1:0]     burst_size,
  output logic                 busy,
  output logic [WB_DW-1:0]     tx_cnt,
  output logic                 err,
  output logic [WB_AW-1:0]     wbm_adr_o,
  output logic [WB_DW/8-1:0]   wbm_sel_o,
  output logic                 wbm_we_o,
  output logic                 wbm_cyc_o,
  output logic                 wbm_stb_o,
  output logic [2:0]           wbm_cti_o,
  output logic [1:0]           wbm_bte_o,
  input  logic [WB_DW-1:0]     wbm_dat_i,
  input  logic                 wbm_ack_i,
  input  logic                 wbm_err_i,
  output logic [WB_DW-1:0]     fifo_d_o,
  output logic                 fifo_wr_o,
  input  logic [FIFO_AW:0]     fifo_cnt_i
);

  localparam logic [WB_AW-1:0] DEPTH    = WB_AW'(2**FIFO_AW);
  localparam logic [WB_AW-1:0] ADR_STEP = WB_AW'(WB_DW/8);
  localparam logic [WB_AW-1:0] ONE      = WB_AW'(1);

  state_t             state_q, state_d;
  logic [WB_AW-1:0]   adr_q, adr_d;
  logic [WB_AW-1:0]   remaining_q, remaining_d;
  logic [WB_AW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [WB_AW-1:0]   burst_q, burst_d;
  logic [WB_DW-1:0]   tx_cnt_q, tx_cnt_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic               cyc_q, cyc_d;

  logic [WB_AW-1:0]   eff_burst;
  logic [WB_AW-1:0]   blen_raw;
  logic [WB_AW-1:0]   blen;
  logic [WB_AW-1:0]   free;

  // Burst length is capped at the FIFO depth so a huge burst_size can never stall forever.
  assign eff_burst = (burst_q == '0) ? ONE : burst_q;
  assign blen_raw  = (eff_burst < remaining_q) ? eff_burst : remaining_q;
  assign blen      = (blen_raw > DEPTH) ? DEPTH : blen_raw;
  assign free      = DEPTH - WB_AW'(fifo_cnt_i);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= ST_IDLE;
      adr_q       <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      burst_q     <= '0;
      tx_cnt_q    <= '0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      cyc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      adr_q       <= adr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_q     <= burst_d;
      tx_cnt_q    <= tx_cnt_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
      cyc_q       <= cyc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    adr_d       = adr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    burst_d     = burst_q;
    tx_cnt_d    = tx_cnt_q;
    busy_d      = busy_q;
    err_d       = err_q;
    cyc_d       = cyc_q;
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_WAIT;
          busy_d      = 1'b1;
          adr_d       = start_adr;
          remaining_d = buf_size;
          burst_d     = burst_size;
          tx_cnt_d    = '0;
          err_d       = 1'b0;
        end
      end
      ST_WAIT: begin
        if (remaining_q == '0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (free >= blen) begin
          state_d    = ST_ACTIVE;
          cyc_d      = 1'b1;
          beat_cnt_d = blen;
        end
      end
      ST_ACTIVE: begin
        if (wbm_err_i) begin
          state_d = ST_IDLE;
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
        end else if (wbm_ack_i) begin
          adr_d       = adr_q + ADR_STEP;
          tx_cnt_d    = tx_cnt_q + 1'b1;
          remaining_d = remaining_q - ONE;
          beat_cnt_d  = beat_cnt_q - ONE;
          if (beat_cnt_q == ONE) begin
            state_d = ST_WAIT;
            cyc_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign busy      = busy_q;
  assign tx_cnt    = tx_cnt_q;
  assign err       = err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_sel_o = '1;
  assign wbm_we_o  = 1'b0;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_cti_o = !cyc_q ? CTI_CLASSIC : ((beat_cnt_q == ONE) ? CTI_EOB : CTI_INC);
  assign wbm_bte_o = BTE_LINEAR;
  assign fifo_d_o  = wbm_dat_i;
  // A bus error in the same cycle as ack wins, so the errored word never reaches the FIFO.
  assign fifo_wr_o = wbm_ack_i & cyc_q & ~wbm_err_i;

endmodule

// File: tb/tb_wb_stream_writer_ctrl.sv
// Directed bench for wb_stream_writer_ctrl: zero-wait slave, beat logger, per-scenario tasks.
module tb_wb_stream_writer_ctrl;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_n_i = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] start_adr = '0;
  logic [31:0] buf_size = '0;
  logic [31:0] burst_size = '0;
  logic        busy;
  logic [31:0] tx_cnt;
  logic        err;
  logic [31:0] wbm_adr_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        wbm_err_i;
  logic [31:0] fifo_d_o;
  logic        fifo_wr_o;
  logic [5:0]  fifo_cnt_i = '0;

  int pass_cnt = 0;
  int total_cnt = 0;
  int ack_count = 0;
  int err_at = -1;

  logic [31:0] log_adr [0:255];
  logic [2:0]  log_cti [0:255];
  logic [31:0] log_dat [0:255];
  int          log_n = 0;
  int          busy_cycles = 0;
  int          cyc_rises = 0;
  logic        prev_cyc = 1'b0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_stream_writer_ctrl #(.WB_AW(32), .WB_DW(32), .FIFO_AW(5)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .enable(enable),
    .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size),
    .busy(busy), .tx_cnt(tx_cnt), .err(err),
    .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o),
    .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
    .wbm_err_i(wbm_err_i), .fifo_d_o(fifo_d_o), .fifo_wr_o(fifo_wr_o),
    .fifo_cnt_i(fifo_cnt_i)
  );

  // Zero-wait slave; data is derived from the address so each word is checkable.
  assign wbm_err_i = wbm_cyc_o && (ack_count == err_at);
  assign wbm_ack_i = wbm_cyc_o && wbm_stb_o && !wbm_err_i;
  assign wbm_dat_i = wbm_adr_o ^ 32'hA5A5_0000;

  always @(posedge wb_clk_i) if (fifo_wr_o) ack_count <= ack_count + 1;

  always @(negedge wb_clk_i) begin
    if (fifo_wr_o && log_n < 256) begin
      log_adr[log_n] <= wbm_adr_o;
      log_cti[log_n] <= wbm_cti_o;
      log_dat[log_n] <= fifo_d_o;
      log_n          <= log_n + 1;
    end
    if (busy) busy_cycles <= busy_cycles + 1;
    if (wbm_cyc_o && !prev_cyc) cyc_rises <= cyc_rises + 1;
    prev_cyc <= wbm_cyc_o;
  end

  task automatic start(input logic [31:0] a, input logic [31:0] s, input logic [31:0] b);
    @(negedge wb_clk_i);
    start_adr = a; buf_size = s; burst_size = b; enable = 1'b1;
    @(negedge wb_clk_i);
    enable = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 500) begin
      @(negedge wb_clk_i);
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset();
    #2 wb_rst_n_i = 1'b0;
    #2;
    total_cnt++;
    if ({busy, err, wbm_cyc_o, wbm_stb_o} !== 4'b0000)
      $display("FAIL reset_flags: busy/err/cyc/stb=%b expected 0000", {busy, err, wbm_cyc_o, wbm_stb_o});
    else pass_cnt++;
    total_cnt++;
    if (tx_cnt !== 32'd0 || wbm_adr_o !== 32'd0 || wbm_cti_o !== 3'b000)
      $display("FAIL reset_regs: tx_cnt=%h adr=%h cti=%b expected 0,0,000", tx_cnt, wbm_adr_o, wbm_cti_o);
    else pass_cnt++;
    total_cnt++;
    if (wbm_sel_o !== 4'hF || wbm_we_o !== 1'b0 || wbm_bte_o !== 2'b00)
      $display("FAIL reset_consts: sel=%h we=%b bte=%b expected f,0,00", wbm_sel_o, wbm_we_o, wbm_bte_o);
    else pass_cnt++;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    @(negedge wb_clk_i);
  endtask

  task automatic test_two_bursts();
    int lb, bb, cb;
    bit ok;
    logic [31:0] ea;
    logic [2:0] ec;
    lb = log_n; bb = busy_cycles; cb = cyc_rises;
    start(32'h100, 32'd8, 32'd4);
    wait_idle(ok);
    total_cnt++;
    if (!ok) $display("FAIL t1_timeout: busy=%b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (log_n - lb != 8) $display("FAIL t1_beats: got %0d expected 8", log_n - lb); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      ea = 32'h100 + 32'(4 * i);
      ec = (i % 4 == 3) ? 3'b111 : 3'b010;
      total_cnt++;
      if (log_adr[lb+i] !== ea || log_cti[lb+i] !== ec || log_dat[lb+i] !== (ea ^ 32'hA5A5_0000))
        $display("FAIL t1_beat%0d: adr=%h cti=%b dat=%h expected adr=%h cti=%b dat=%h",
                 i, log_adr[lb+i], log_cti[lb+i], log_dat[lb+i], ea, ec, ea ^ 32'hA5A5_0000);
      else pass_cnt++;
    end
    total_cnt++;
    if (tx_cnt !== 32'd8 || err !== 1'b0) $display("FAIL t1_txcnt: tx_cnt=%0d err=%b expected 8,0", tx_cnt, err);
    else pass_cnt++;
    total_cnt++;
    if (busy_cycles - bb != 11) $display("FAIL t1_busy_len: got %0d expected 11", busy_cycles - bb);
    else pass_cnt++;
    total_cnt++;
    if (cyc_rises - cb != 2) $display("FAIL t1_bursts: got %0d expected 2", cyc_rises - cb); else pass_cnt++;
  endtask

  task automatic test_short_tail();
    int lb, bb, cb;
    bit ok;
    logic [31:0] ea;
    logic [2:0] ec;
    lb = log_n; bb = busy_cycles; cb = cyc_rises;
    start(32'h200, 32'd6, 32'd4);
    wait_idle(ok);
    total_cnt++;
    if (!ok || log_n - lb != 6) $display("FAIL t2_beats: got %0d ok=%b expected 6", log_n - lb, ok);
    else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      ea = 32'h200 + 32'(4 * i);
      ec = (i == 3 || i == 5) ? 3'b111 : 3'b010;
      total_cnt++;
      if (log_adr[lb+i] !== ea || log_cti[lb+i] !== ec)
        $display("FAIL t2_beat%0d: adr=%h cti=%b expected adr=%h cti=%b", i, log_adr[lb+i], log_cti[lb+i], ea, ec);
      else pass_cnt++;
    end
    total_cnt++;
    if (tx_cnt !== 32'd6 || busy_cycles - bb != 9 || cyc_rises - cb != 2)
      $display("FAIL t2_totals: tx_cnt=%0d busy_len=%0d bursts=%0d expected 6,9,2", tx_cnt, busy_cycles - bb, cyc_rises - cb);
    else pass_cnt++;
  endtask

  task automatic test_fifo_space();
    int lb, cb;
    bit ok;
    lb = log_n; cb = cyc_rises;
    fifo_cnt_i = 6'd30;
    start(32'h300, 32'd4, 32'd4);
    repeat (10) @(negedge wb_clk_i);
    total_cnt++;
    if (wbm_cyc_o !== 1'b0 || busy !== 1'b1 || cyc_rises != cb)
      $display("FAIL t3_hold30: cyc=%b busy=%b bursts=%0d expected 0,1,0", wbm_cyc_o, busy, cyc_rises - cb);
    else pass_cnt++;
    fifo_cnt_i = 6'd29;
    repeat (3) @(negedge wb_clk_i);
    total_cnt++;
    if (wbm_cyc_o !== 1'b0) $display("FAIL t3_hold29: cyc=%b expected 0", wbm_cyc_o); else pass_cnt++;
    fifo_cnt_i = 6'd28;
    @(negedge wb_clk_i);
    total_cnt++;
    if (wbm_cyc_o !== 1'b1 || wbm_adr_o !== 32'h300)
      $display("FAIL t3_go28: cyc=%b adr=%h expected 1,300", wbm_cyc_o, wbm_adr_o);
    else pass_cnt++;
    wait_idle(ok);
    total_cnt++;
    if (!ok || log_n - lb != 4 || tx_cnt !== 32'd4)
      $display("FAIL t3_done: beats=%0d tx_cnt=%0d expected 4,4", log_n - lb, tx_cnt);
    else pass_cnt++;
    fifo_cnt_i = 6'd0;
  endtask

  task automatic test_bus_error();
    int lb, n;
    bit ok;
    lb = log_n;
    err_at = ack_count + 2;
    start(32'h400, 32'd4, 32'd4);
    n = 0;
    while (!wbm_err_i && n < 50) begin
      @(negedge wb_clk_i);
      n++;
    end
    total_cnt++;
    if (wbm_err_i !== 1'b1 || fifo_wr_o !== 1'b0)
      $display("FAIL t4_err_beat: err_i=%b fifo_wr=%b expected 1,0", wbm_err_i, fifo_wr_o);
    else pass_cnt++;
    @(negedge wb_clk_i);
    err_at = -1;
    total_cnt++;
    if (tx_cnt !== 32'd2 || err !== 1'b1 || busy !== 1'b0 || wbm_cyc_o !== 1'b0)
      $display("FAIL t4_abort: tx_cnt=%0d err=%b busy=%b cyc=%b expected 2,1,0,0", tx_cnt, err, busy, wbm_cyc_o);
    else pass_cnt++;
    total_cnt++;
    if (log_n - lb != 2) $display("FAIL t4_writes: got %0d expected 2", log_n - lb); else pass_cnt++;
    start(32'h800, 32'd1, 32'd1);
    total_cnt++;
    if (err !== 1'b0 || busy !== 1'b1) $display("FAIL t4_clear: err=%b busy=%b expected 0,1", err, busy);
    else pass_cnt++;
    wait_idle(ok);
    total_cnt++;
    if (!ok || tx_cnt !== 32'd1 || err !== 1'b0)
      $display("FAIL t4_restart: tx_cnt=%0d err=%b expected 1,0", tx_cnt, err);
    else pass_cnt++;
  endtask

  task automatic test_zero_sizes();
    int lb, bb, cb;
    bit ok;
    logic [31:0] ea;
    bb = busy_cycles; cb = cyc_rises; lb = log_n;
    start(32'h500, 32'd0, 32'd4);
    wait_idle(ok);
    total_cnt++;
    if (!ok || busy_cycles - bb != 1 || cyc_rises != cb || tx_cnt !== 32'd0 || log_n != lb)
      $display("FAIL t5_empty: busy_len=%0d bursts=%0d tx_cnt=%0d expected 1,0,0", busy_cycles - bb, cyc_rises - cb, tx_cnt);
    else pass_cnt++;
    cb = cyc_rises; lb = log_n;
    start(32'h500, 32'd3, 32'd0);
    wait_idle(ok);
    total_cnt++;
    if (!ok || log_n - lb != 3 || cyc_rises - cb != 3 || tx_cnt !== 32'd3)
      $display("FAIL t5_single: beats=%0d bursts=%0d tx_cnt=%0d expected 3,3,3", log_n - lb, cyc_rises - cb, tx_cnt);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      ea = 32'h500 + 32'(4 * i);
      total_cnt++;
      if (log_adr[lb+i] !== ea || log_cti[lb+i] !== 3'b111)
        $display("FAIL t5_beat%0d: adr=%h cti=%b expected adr=%h cti=111", i, log_adr[lb+i], log_cti[lb+i], ea);
      else pass_cnt++;
    end
  endtask

  task automatic test_async_reset();
    int lb, n;
    bit ok;
    start(32'h600, 32'd8, 32'd4);
    n = 0;
    while (!wbm_cyc_o && n < 20) begin
      @(negedge wb_clk_i);
      n++;
    end
    @(negedge wb_clk_i);
    #2 wb_rst_n_i = 1'b0;
    #1;
    total_cnt++;
    if ({wbm_cyc_o, wbm_stb_o, busy} !== 3'b000 || tx_cnt !== 32'd0 || wbm_adr_o !== 32'd0)
      $display("FAIL t6_async: cyc/stb/busy=%b tx_cnt=%0d adr=%h expected 000,0,0", {wbm_cyc_o, wbm_stb_o, busy}, tx_cnt, wbm_adr_o);
    else pass_cnt++;
    @(negedge wb_clk_i);
    wb_rst_n_i = 1'b1;
    lb = log_n;
    start(32'h700, 32'd2, 32'd2);
    wait_idle(ok);
    total_cnt++;
    if (!ok || log_n - lb != 2 || tx_cnt !== 32'd2)
      $display("FAIL t6_restart: beats=%0d tx_cnt=%0d expected 2,2", log_n - lb, tx_cnt);
    else pass_cnt++;
    total_cnt++;
    if (log_adr[lb] !== 32'h700 || log_adr[lb+1] !== 32'h704 || log_cti[lb] !== 3'b010 || log_cti[lb+1] !== 3'b111)
      $display("FAIL t6_beats: adr=%h,%h cti=%b,%b expected 700,704 010,111", log_adr[lb], log_adr[lb+1], log_cti[lb], log_cti[lb+1]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_two_bursts();
    test_short_tail();
    test_fifo_space();
    test_bus_error();
    test_zero_sizes();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
